// File: rtl/arm_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package arm_fetch_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_KILL = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // One prefetch buffer entry: the fetch address and the word returned for it.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Instruction addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] pc_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/arm_fetch_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO of {pc, inst} pairs.
// Flush empties the buffer and overrides any push or pop in the same cycle.
module arm_fetch_fifo
  import arm_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Entry storage; contents only matter while counted, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Head entry is presented directly; an empty buffer reads as zero.
  always_comb begin
    dout = '0;
    if (count != '0) begin
      dout = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/arm_fetch.sv
// Instruction fetch unit: issues word reads, buffers returned words with
// their addresses, and streams them to the decoder.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  FETCH_IDLE | no request outstanding; waits for buffer credit and !halt
//  FETCH_REQ  | imem_req high at fetch_pc until the memory grants
//  FETCH_WAIT | granted; the returned word is pushed with its pc
//  FETCH_KILL | granted before a redirect; the returned word is discarded
module arm_fetch
  import arm_fetch_pkg::*;
#(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_idle
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t     state;
  fetch_state_t     state_nxt;
  logic [31:0]      fetch_pc;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  fetch_entry_t     fifo_din;
  fetch_entry_t     fifo_dout;
  logic             has_credit;

  // Only one request is ever outstanding, so a free slot now is a free slot
  // when the data comes back.
  assign has_credit = fifo_count < CNT_W'(FIFO_DEPTH);

  // A redirect empties the buffer and discards a head pop in the same cycle.
  assign fifo_flush = redirect_valid;
  assign fifo_pop   = inst_valid && inst_ready && !redirect_valid;
  assign fifo_din   = '{pc: fetch_pc, inst: imem_rdata};

  // Next-state logic; redirect outranks halt, grant and return.
  always_comb begin
    state_nxt = state;
    fifo_push = 1'b0;
    case (state)
      FETCH_IDLE: begin
        if (!redirect_valid && !halt && has_credit) begin
          state_nxt = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (redirect_valid) begin
          // An accepted request now belongs to the old stream.
          state_nxt = imem_gnt ? FETCH_KILL : FETCH_REQ;
        end else if (imem_gnt) begin
          state_nxt = FETCH_WAIT;
        end else if (halt) begin
          state_nxt = FETCH_IDLE;
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          state_nxt = FETCH_IDLE;
          fifo_push = !redirect_valid;
        end else if (redirect_valid) begin
          state_nxt = FETCH_KILL;
        end
      end
      FETCH_KILL: begin
        if (imem_rvalid) begin
          state_nxt = FETCH_IDLE;
        end
      end
      default: state_nxt = FETCH_IDLE;
    endcase
  end

  // State register and fetch address; the address advances only on a push.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= FETCH_IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        fetch_pc <= pc_align(redirect_pc);
      end else if (fifo_push) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
    end
  end

  assign imem_req   = (state == FETCH_REQ);
  assign imem_addr  = fetch_pc;
  assign fetch_idle = halt && (state == FETCH_IDLE);
  assign inst_valid = (fifo_count != '0);
  assign inst       = fifo_dout.inst;
  assign inst_pc    = fifo_dout.pc;

  arm_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_arm_fetch.sv
// Bench for arm_fetch: directed scenarios followed by randomized traffic,
// checked against a stream-level model of the fetch unit.
module tb_arm_fetch;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fetch_idle;

  always #5 clk = ~clk;

  arm_fetch #(
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .fetch_idle     (fetch_idle)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // memory environment
  int          gnt_pct = 100;
  int          lat_min = 0;
  int          lat_max = 0;
  bit          ready_rand = 0;
  bit          mem_pending = 0;
  logic [31:0] mem_addr = '0;
  int          mem_lat = 0;

  // reference model: the stream of addresses the unit should fetch and deliver
  logic [31:0] exp_fetch;
  logic [31:0] exp_pop;
  int          m_count;
  bit          m_live;
  bit          prev_hold;
  logic [31:0] prev_addr;

  int          n_gnt = 0;
  int          n_pop = 0;
  logic [31:0] last_gnt_addr = '0;
  logic [31:0] last_pop_pc = '0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_fetch = RST_PC;
    exp_pop   = RST_PC;
    m_count   = 0;
    m_live    = 0;
    prev_hold = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: drive memory/redirect, check outputs, advance the model.
  task automatic step(input logic redir, input logic [31:0] rpc);
    logic gnt_ev;
    logic pop_ev;
    if (ready_rand) inst_ready = 1'($urandom_range(1, 0));
    imem_rvalid    = mem_pending && (mem_lat == 0);
    imem_rdata     = imem_rvalid ? word_of(mem_addr) : 32'h0;
    imem_gnt       = imem_req && !mem_pending && (int'($urandom_range(99, 0)) < gnt_pct);
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    chk("one_outstanding", {31'b0, imem_req && mem_pending}, 32'd0);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_count != 0});
    if (!inst_valid) begin
      chk("empty_inst", inst, 32'h0);
      chk("empty_pc", inst_pc, 32'h0);
    end
    if (prev_hold) begin
      chk("req_held", {31'b0, imem_req}, 32'd1);
      chk("addr_stable", imem_addr, prev_addr);
    end
    gnt_ev = imem_req && imem_gnt;
    pop_ev = inst_valid && inst_ready;
    if (gnt_ev) begin
      n_gnt++;
      last_gnt_addr = imem_addr;
      if (!redir) begin
        chk("fetch_addr", imem_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    if (pop_ev && !redir) begin
      chk("pop_pc", inst_pc, exp_pop);
      chk("pop_inst", inst, word_of(exp_pop));
      n_pop++;
      last_pop_pc = inst_pc;
      exp_pop = exp_pop + 32'd4;
      m_count--;
    end
    if (imem_rvalid) begin
      if (m_live && !redir) m_count++;
      m_live = 0;
      mem_pending = 0;
    end else if (mem_pending) begin
      mem_lat--;
    end
    if (gnt_ev) begin
      m_live      = !redir;
      mem_pending = 1;
      mem_addr    = imem_addr;
      mem_lat     = int'($urandom_range(lat_max, lat_min));
    end
    if (redir) begin
      exp_fetch = rpc & 32'hFFFF_FFFC;
      exp_pop   = rpc & 32'hFFFF_FFFC;
      m_count   = 0;
      m_live    = 0;
    end
    prev_hold = imem_req && !imem_gnt && !redir && !halt;
    prev_addr = imem_addr;
    tick();
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 32'h0);
  endtask

  task automatic wait_gnt(input int target, input int budget, input string tag);
    int i;
    i = 0;
    while (n_gnt < target && i < budget) begin
      step(1'b0, 32'h0);
      i++;
    end
    chk(tag, {31'b0, n_gnt >= target}, 32'd1);
  endtask

  task automatic do_reset();
    rst_b          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_pending    = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    logic        redir;
    logic [31:0] rpc;

    // 1: reset values, then in-order streaming at latency 1
    halt = 1'b0; inst_ready = 1'b0; rst_b = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0;
    #12;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_idle", {31'b0, fetch_idle}, 32'd0);
    do_reset();
    inst_ready = 1'b1; gnt_pct = 100; lat_min = 0; lat_max = 0;
    n_gnt = 0; n_pop = 0;
    run(12);
    chk("t1_pops", {31'b0, n_pop >= 3}, 32'd1);

    // 2: credit limit with a stalled decoder
    do_reset();
    inst_ready = 1'b0; n_gnt = 0;
    run(15);
    chk("t2_grants", n_gnt, 32'd2);
    chk("t2_req_low", {31'b0, imem_req}, 32'd0);
    chk("t2_valid", {31'b0, inst_valid}, 32'd1);
    inst_ready = 1'b1;
    step(1'b0, 32'h0);
    inst_ready = 1'b0;
    wait_gnt(3, 10, "t2_refill_gnt");
    chk("t2_refill_addr", last_gnt_addr, 32'h8);
    run(6);
    chk("t2_grants_after", n_gnt, 32'd3);

    // 3: redirect while waiting for data
    do_reset();
    inst_ready = 1'b0; lat_min = 2; lat_max = 2; n_gnt = 0;
    wait_gnt(1, 10, "t3_gnt");
    step(1'b1, 32'h100);
    chk("t3_flushed", {31'b0, inst_valid}, 32'd0);
    lat_min = 0; lat_max = 0;
    run(4);
    chk("t3_dropped", {31'b0, inst_valid}, 32'd0);
    inst_ready = 1'b1; n_pop = 0; i = 0;
    while (n_pop == 0 && i < 20) begin
      step(1'b0, 32'h0);
      i++;
    end
    chk("t3_first_pc", last_pop_pc, 32'h100);

    // 4: redirect together with rvalid and a pop
    do_reset();
    inst_ready = 1'b0; n_gnt = 0;
    wait_gnt(2, 20, "t4_gnt");
    chk("t4_pre_valid", {31'b0, inst_valid}, 32'd1);
    inst_ready = 1'b1;
    step(1'b1, 32'h2000_0043);
    chk("t4_flushed", {31'b0, inst_valid}, 32'd0);
    inst_ready = 1'b0;
    wait_gnt(3, 10, "t4_regnt");
    chk("t4_redir_addr", last_gnt_addr, 32'h2000_0040);

    // 5: halt withdraws an ungranted request; buffer still drains
    do_reset();
    inst_ready = 1'b0; n_gnt = 0;
    wait_gnt(1, 10, "t5_gnt");
    gnt_pct = 0; i = 0;
    while (!imem_req && i < 10) begin
      step(1'b0, 32'h0);
      i++;
    end
    chk("t5_req", {31'b0, imem_req}, 32'd1);
    halt = 1'b1;
    step(1'b0, 32'h0);
    chk("t5_req_drop", {31'b0, imem_req}, 32'd0);
    chk("t5_idle", {31'b0, fetch_idle}, 32'd1);
    n_pop = 0; inst_ready = 1'b1;
    run(3);
    chk("t5_drained", n_pop, 32'd1);
    chk("t5_drain_pc", last_pop_pc, RST_PC);
    chk("t5_still_idle", {31'b0, fetch_idle}, 32'd1);
    halt = 1'b0; gnt_pct = 100; inst_ready = 1'b0;

    // 6: async reset mid-request, stray response afterwards
    do_reset();
    inst_ready = 1'b1; lat_min = 3; lat_max = 3; n_gnt = 0;
    wait_gnt(1, 10, "t6_gnt");
    step(1'b0, 32'h0);
    #2;
    rst_b = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    #1;
    chk("t6_rst_req", {31'b0, imem_req}, 32'd0);
    chk("t6_rst_valid", {31'b0, inst_valid}, 32'd0);
    halt = 1'b1;
    model_reset();
    tick();
    rst_b = 1'b1;
    i = 0;
    while (mem_pending && i < 10) begin
      step(1'b0, 32'h0);
      i++;
    end
    chk("t6_stray_done", {31'b0, mem_pending}, 32'd0);
    chk("t6_no_valid", {31'b0, inst_valid}, 32'd0);
    halt = 1'b0; lat_min = 0; lat_max = 0; n_gnt = 0;
    wait_gnt(1, 10, "t6_regnt");
    chk("t6_restart_addr", last_gnt_addr, RST_PC);

    // randomized traffic with redirects (including near the address wrap) and halts
    do_reset();
    ready_rand = 1; gnt_pct = 60; lat_min = 0; lat_max = 3; n_pop = 0;
    for (int k = 0; k < 3000; k++) begin
      redir = (int'($urandom_range(99, 0)) < 3);
      if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
      else rpc = $urandom;
      if ($urandom_range(99, 0) < 4) halt = ~halt;
      step(redir, rpc);
    end
    halt = 1'b0;
    run(20);
    chk("rand_progress", {31'b0, n_pop > 100}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
